fifo_param: RTL
===============

Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the UART byte FIFO.
- Sits between the UART RX deserialiser and host-side consumer, and between host and TX serialiser.
- Adds over the previous generation:
  - configurable width and depth
  - simultaneous read+write in one cycle
  - almost-full/almost-empty thresholds
  - occupancy count
  - read-data valid strobe
  - synchronous flush
  - overflow/underflow error pulses

Parameters:
- DATA_WIDTH, 8, bits per entry (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- ALMOST_FULL_TH, 12, Almost_Full asserted when Count ≥ this (1..DEPTH)
- ALMOST_EMPTY_TH, 4, Almost_Empty asserted when Count ≤ this (0..DEPTH-1)

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Clear  in  1  synchronous flush, active-high
- Write  in  1  write request
- Din  in  DATA_WIDTH  write data
- Read  in  1  read request
- Dout  out  DATA_WIDTH  registered read data
- Dout_Valid  out  1  one-cycle pulse: Dout holds newly popped entry
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- Almost_Full  out  1  Count ≥ ALMOST_FULL_TH
- Almost_Empty  out  1  Count ≤ ALMOST_EMPTY_TH
- Count  out  $clog2(DEPTH)+1  current occupancy
- Overflow  out  1  one-cycle pulse: write rejected
- Underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (async assert, sync deassert at top level):
  - pointers = 0, Count = 0, Dout = 0.
  - Dout_Valid, Overflow, Underflow = 0.
  - Empty = 1, Full = 0, Almost_Empty = 1, Almost_Full = 0.
  - Memory contents not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 → 0. Count is separate, DEPTH+1 states.
- Flags are combinational from the registered Count. Count updates on the edge that accepts the operation.
- Accept rules, evaluated per cycle on pre-edge state:
  - rd_ok = Read & !Empty
  - wr_ok = Write & (!Full | rd_ok); writing while full is allowed only with a same-cycle accepted read.
- Count update:
  - +1 for wr_ok only
  - -1 for rd_ok only
  - unchanged when both or neither are accepted
- Read latency: one cycle. On rd_ok, at the next edge Dout = Mem[rd_ptr] and Dout_Valid = 1 for exactly one cycle.
- Dout holds its last value when no read is accepted.
- Simultaneous read+write while empty: the read is rejected (Underflow pulses) and the write is accepted. There is no fall-through; data becomes readable the following cycle.
- Simultaneous read+write while full: both are accepted. The read returns the oldest entry; the write lands in the freed slot (wr_ptr == rd_ptr; memory read precedes write). Count stays DEPTH.
- Overflow = registered (Write & !wr_ok). Underflow = registered (Read & !rd_ok). Each is a one-cycle pulse per rejected request; state is unchanged by a rejected request.
- Clear:
  - pointers and Count return to 0.
  - Read/Write in that cycle are ignored.
  - No Overflow/Underflow pulse.
  - Dout_Valid = 0 next cycle; Dout retains its value.
  - Clear has priority over all operations.
- Reset mid-operation: all state returns to reset values immediately. A pending Dout_Valid is cancelled.
- Parameter violations (DEPTH not a power of two, thresholds out of range) are caught by elaboration-time assertions.

Decomposition:
- Package fifo_pkg holds:
  - the clog2-based width helper
  - the pointer/count width localparam calculation
  - the default DATA_WIDTH/DEPTH constants shared with the UART top
- Sub-module fifo_mem_2p: DEPTH×DATA_WIDTH, one synchronous write port, one synchronous registered read port with read-before-write semantics on address collision.
- fifo_param holds the pointers, Count, flags and error logic.

Test Plan (DATA_WIDTH=8, DEPTH=16, AF=12, AE=4):
- Reset, then write 0x00..0x0F over 16 cycles → Count = 16, Full = 1.
  - Almost_Full rises on the edge where Count becomes 12.
  - Almost_Empty falls when Count becomes 5.
  - A 17th write yields Overflow pulse = 1; Count stays 16.
- From full, 16 reads → Dout sequence 0x00..0x0F, each with Dout_Valid one cycle after Read; final Empty = 1. A 17th read yields an Underflow pulse; Dout stays 0x0F; no Dout_Valid.
- Full FIFO, Read=Write=1 with Din=0xAA → Dout = 0x00, Count stays 16, no Overflow. After draining, 0xAA emerges last.
- Empty FIFO, Read=Write=1 with Din=0x55 → Underflow pulse, Count = 1. The next-cycle read returns 0x55.
- Pointer wrap:
  - Write 10 / read 10, three times (30 entries through a 16-deep FIFO).
  - Each popped value matches the pushed order (incrementing pattern); Count returns to 0.
- Write 5 entries, then Clear asserted with Write=1 → Count = 0, Empty = 1, no Overflow. Reset asserted mid-burst asynchronously → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default geometry for the parametrised FIFO.
// Contents: default width/depth constants shared with the UART top, pointer
// and count width helpers, and a power-of-two check used at elaboration.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 16;

  // Pointer width: log2 of the depth (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width: one extra bit so the value DEPTH itself is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port FIFO storage: DEPTH x DATA_WIDTH array, one synchronous write port
// and one registered read port. On an address collision the read returns the
// old contents (read-before-write). The read register resets to zero and holds
// its value while re is low; the array itself is not reset.
// Ports: clk, rst (async, active-high), we/waddr/wdata, re/raddr, rdata.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W    = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Read data only changes when a read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Storage array; both ports sample on the same edge, so a colliding read
  // sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty
// thresholds, read-data valid strobe, synchronous flush and overflow/underflow
// error pulses. Storage lives in fifo_mem_2p; this level owns pointers, count,
// flags and error logic.
// Ports: Clock, Reset (async, active-high), Clear (sync flush), Write/Din,
// Read, Dout/Dout_Valid, Full, Empty, Almost_Full, Almost_Empty, Count,
// Overflow, Underflow.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH           = DEFAULT_DEPTH,
  parameter int unsigned ALMOST_FULL_TH  = 12,
  parameter int unsigned ALMOST_EMPTY_TH = 4,
  localparam int unsigned PTR_W          = ptr_width(DEPTH),
  localparam int unsigned CNT_W          = cnt_width(DEPTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic                  Write,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic                  Read,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  Dout_Valid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [CNT_W-1:0]      Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  // Elaboration-time parameter checks.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "fifo_param: DATA_WIDTH must be >= 1");
  end
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_param: DEPTH must be a power of two >= 2");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_param: ALMOST_FULL_TH out of range 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH >= DEPTH) begin : g_bad_ae
    $fatal(1, "fifo_param: ALMOST_EMPTY_TH out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic rd_ok, wr_ok, mem_we, mem_re;

  // Flags derive from the registered count only.
  assign Full         = (count_q == CNT_W'(DEPTH));
  assign Empty        = (count_q == '0);
  assign Almost_Full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
  assign Almost_Empty = (count_q <= CNT_W'(ALMOST_EMPTY_TH));

  // A write into a full FIFO is legal only alongside an accepted read.
  assign rd_ok  = Read & ~Empty;
  assign wr_ok  = Write & (~Full | rd_ok);
  assign mem_we = wr_ok & ~Clear;
  assign mem_re = rd_ok & ~Clear;

  // Next-state: Clear overrides everything and suppresses error pulses.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    if (Clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_ok && !rd_ok)      count_d = count_q + CNT_W'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - CNT_W'(1);
      dout_valid_d = rd_ok;
      overflow_d   = Write & ~wr_ok;
      underflow_d  = Read & ~rd_ok;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (Clock),
    .rst  (Reset),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(Din),
    .re   (mem_re),
    .raddr(rd_ptr_q),
    .rdata(Dout)
  );

  assign Count      = count_q;
  assign Dout_Valid = dout_valid_q;
  assign Overflow   = overflow_q;
  assign Underflow  = underflow_q;

endmodule
